// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: default sizes and requester ids.
package mem_pkg;

  localparam int WORD_W       = 32;
  localparam int ADDR_W_DEF   = 32;
  localparam int DEPTH_DEF    = 128;
  localparam int MAX_WAIT_DEF = 4;

  // Requester identity; used to name the winner of the current cycle.
  typedef enum logic {
    REQ_C = 1'b0,
    REQ_D = 1'b1
  } req_e;

endpackage : mem_pkg

// File: rtl/mem_starve_ctr.sv
// Saturating count of consecutive cycles the debug port was kept waiting.
// When the count reaches MAX_WAIT the debug port takes priority on the next contended cycle.
module mem_starve_ctr
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_req,
  input  logic          d_gnt,
  output logic          d_prio,
  output logic [CW-1:0] wait_cnt
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart whenever D is idle or served, otherwise count up and saturate.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (!d_req || d_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(MAX_WAIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign d_prio   = (cnt_q == CW'(MAX_WAIT));
  assign wait_cnt = cnt_q;

endmodule : mem_starve_ctr

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port unified memory.
// C (CPU) has fixed priority; D (debug/loader) is guaranteed a slot after MAX_WAIT denials.
// Grants are combinational; read data, error and valid return one cycle later.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int AW       = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [AW-1:0]     c_addr,
  input  logic [WORD_W-1:0] c_wdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              c_gnt,
  output logic              d_gnt,
  output logic [WORD_W-1:0] c_rdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              c_rvalid,
  output logic              d_rvalid,
  output logic              c_err,
  output logic              d_err,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic          d_prio;
  logic [CW-1:0] wait_cnt;
  logic          any_gnt;
  logic          sel_we;
  logic          in_range;
  req_e          winner;

  logic              c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic              c_err_q, c_err_d, d_err_q, d_err_d;
  logic [WORD_W-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;

  mem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (CW)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .d_req    (d_req),
    .d_gnt    (d_gnt),
    .d_prio   (d_prio),
    .wait_cnt (wait_cnt)
  );

  // Arbitration and memory-side mux: pick one winner and present its access to the memory.
  always_comb begin
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    winner    = REQ_C;
    mem_addr  = '0;
    mem_wdata = '0;
    sel_we    = 1'b0;
    if (!rst) begin
      if (d_req && (!c_req || d_prio)) begin
        d_gnt  = 1'b1;
        winner = REQ_D;
      end else if (c_req) begin
        c_gnt  = 1'b1;
      end
    end
    any_gnt = c_gnt || d_gnt;
    if (any_gnt) begin
      mem_addr  = (winner == REQ_D) ? d_addr  : c_addr;
      mem_wdata = (winner == REQ_D) ? d_wdata : c_wdata;
      sel_we    = (winner == REQ_D) ? d_we    : c_we;
    end
    // Out-of-range accesses are granted but never reach the memory.
    in_range = (mem_addr < AW'(DEPTH));
    mem_we   = any_gnt && in_range && sel_we;
    mem_re   = any_gnt && in_range && !sel_we;
  end

  // Response next-state: a grant produces a one-cycle valid; reads capture data, writes hold it.
  always_comb begin
    c_rvalid_d = c_gnt;
    d_rvalid_d = d_gnt;
    c_err_d    = c_gnt && !in_range;
    d_err_d    = d_gnt && !in_range;
    c_rdata_d  = c_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (c_gnt) begin
      if (!in_range)    c_rdata_d = '0;
      else if (!sel_we) c_rdata_d = mem_rdata;
    end
    if (d_gnt) begin
      if (!in_range)    d_rdata_d = '0;
      else if (!sel_we) d_rdata_d = mem_rdata;
    end
  end

  // Response registers; reset also cancels a pulse already scheduled for this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_err_q    <= c_err_d;
      d_err_q    <= d_err_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_err    = c_err_q;
  assign d_err    = d_err_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter for the single-port unified word-addressed memory in the multicycle datapath.
- Requester C is the CPU (multicycle control/datapath; instruction fetch and lw/sw). Requester D is the debug/loader port (program load, result readback).
- Issues at most one memory access per cycle. Fixed priority to C, with a starvation guard for D.
- Registers read data and errors back to the winning requester.

Parameters:
DEPTH, 128, number of valid word addresses (0..DEPTH-1)
MAX_WAIT, 4, consecutive denied cycles after which D wins the next contended cycle
AW, 32, address width

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
c_req, d_req  input  1 each  access request; held until gnt
c_we, d_we  input  1 each  1 = write, 0 = read; valid with req
c_addr, d_addr  input  AW each  word address
c_wdata, d_wdata  input  32 each  write data
c_gnt, d_gnt  output  1 each  combinational; access performed this cycle
c_rdata, d_rdata  output  32 each  registered read data
c_rvalid, d_rvalid  output  1 each  one-cycle pulse; response for last granted access (reads and writes)
c_err, d_err  output  1 each  one-cycle pulse with rvalid; address out of range
mem_addr  output  AW  to memory Address
mem_wdata  output  32  to memory w_data
mem_we  output  1  to memory we (write commits at posedge)
mem_re  output  1  to memory re
mem_rdata  input  32  from memory mem_data (combinational read)

Behaviour:
- Reset: while rst=1 all gnt, mem_we and mem_re are forced to 0. At the clock edge, rvalid, err, rdata and wait_cnt are cleared to 0.
- Arbitration (combinational, cycle N):
  - Only one request: it wins.
  - Both requesting: C wins unless wait_cnt == MAX_WAIT, in which case D wins.
  - Exactly one gnt per cycle at most; gnt may only rise when the matching req=1.
- Winner drives mem_addr/mem_wdata. Neither requesting: mem_addr = 0, mem_wdata = 0, mem_we = mem_re = 0.
- In range (addr < DEPTH):
  - Write: mem_we=1, mem_re=0.
  - Read: mem_re=1, mem_we=0.
  - At the posedge ending cycle N, rdata_x <= mem_rdata for reads; rdata_x holds its previous value for writes.
- Out of range (addr >= DEPTH): gnt still asserts, mem_we = mem_re = 0, memory untouched; cycle N+1: err_x=1, rdata_x=0.
- Response: rvalid_x=1 in cycle N+1 only; fixed latency 1. The requester may issue a new req in N+1; back-to-back grants are allowed.
- wait_cnt (registered, saturating at MAX_WAIT):
  - +1 on each cycle with d_req=1 and d_gnt=0.
  - Cleared on d_gnt or d_req=0.
  - Width is clog2(MAX_WAIT+1).
- C is never starved: after any D grant, wait_cnt=0, so C wins the next contended cycle.
- Reset mid-operation: rst=1 in the grant cycle means no write is issued and no rvalid appears in N+1. rst in N+1 clears an already-issued pulse at the following edge.
- Requester changes addr/we/wdata while ungranted: no effect; arbitration uses current-cycle values only.

Decomposition:
- Shared package mem_pkg: DEPTH default, word/addr widths, requester index enum (REQ_C, REQ_D).
- One natural sub-module: mem_starve_ctr (the saturating wait counter plus its priority-flip output). Arbitration mux and response registers stay in mem_arbiter.

Test Plan:
- rst=1 with c_req=d_req=1 -> c_gnt=d_gnt=mem_we=mem_re=0; after release, all rvalid/err/rdata = 0.
- C read addr 64 (preloaded 0x20110000) -> c_gnt=1 and mem_re=1 cycle N; c_rvalid=1, c_rdata=0x20110000 cycle N+1 only.
- D write addr 24 data 0xDEADBEEF, then D read addr 24 -> d_rvalid after each, d_err=0, read returns 0xDEADBEEF.
- Continuous contention (both req every cycle, MAX_WAIT=4) -> grants C,C,C,C,D repeating; wait_cnt sequence 0,1,2,3,4,0.
- D write addr 200 data 0x1 -> d_gnt=1, mem_we=0; d_rvalid=d_err=1, d_rdata=0 next cycle; memory contents unchanged.
- C read granted with rst=1 the same cycle -> c_rvalid=0 next cycle; C read granted then rst=1 in N+1 -> pulse seen in N+1, cleared in N+2.
